hazard_ctrl: RTL and testbench

- Pipeline hazard and flow-control block for the 5-stage MIPS datapath; it is the parametrised successor to the current pipeline, which has no stall or forwarding support.
- Tracks in-flight register writers in the E/M/W stages with a shifting scoreboard.
- Produces registered forwarding selects, load-use stalls, and redirect flushes for the F/D/E/M pipeline registers.
- Keeps saturating stall and flush performance counters readable through the debug bus.

---
 rtl/pipeline_pkg.sv | 36 +++
 rtl/sat_counter.sv | 19 +
 rtl/hazard_ctrl.sv | 116 +++++++++++
 tb/tb_hazard_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared hazard-control types and helpers
package pipeline_pkg;

  // Address field is sized for the widest register file we expect to bolt on.
  localparam int SB_WA_W = 8;

  typedef struct packed {
    logic               valid;
    logic               we;
    logic [SB_WA_W-1:0] wa;
    logic               is_load;
  } sb_entry_t;

  localparam sb_entry_t SB_EMPTY = '0;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_t;

  function automatic logic sb_match(sb_entry_t e, logic [SB_WA_W-1:0] ra,
                                    logic use_op, logic load_only);
    return e.valid && e.we && (e.wa == ra) && (ra != '0) && use_op &&
           (!load_only || e.is_load);
  endfunction

  // Youngest producer wins; W producers are served by the write-through regfile.
  function automatic fwd_sel_t pick_fwd(logic e_hit, logic m_hit, logic w_hit);
    if (e_hit)      return FWD_MEM;
    else if (m_hit) return FWD_WB;
    else if (w_hit) return FWD_RF;
    else            return FWD_RF;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - scoreboard-based stall, flush and forwarding control
module hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int FWD_EN     = 1,
  parameter int CNT_W      = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  d_valid,
  input  logic [REG_ADDR_W-1:0] d_ra0,
  input  logic [REG_ADDR_W-1:0] d_ra1,
  input  logic                  d_use0,
  input  logic                  d_use1,
  input  logic                  d_rf_we,
  input  logic [REG_ADDR_W-1:0] d_wa,
  input  logic                  d_is_load,
  input  logic                  m_redirect,
  output logic                  stall_f,
  output logic                  stall_d,
  output logic                  flush_d,
  output logic                  flush_e,
  output logic                  flush_m,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  sb_entry_t          sb_e, sb_m, sb_w, d_entry;
  fwd_sel_t           fwd_a_q, fwd_b_q;
  logic               armed;
  logic [SB_WA_W-1:0] ra0, ra1;
  logic               e0, e1, e0_ld, e1_ld, m0, m1, w0, w1;
  logic               hazard, redirect, e_bubble;

  assign ra0 = SB_WA_W'(d_ra0);
  assign ra1 = SB_WA_W'(d_ra1);

  always_comb begin
    e0    = sb_match(sb_e, ra0, d_use0, 1'b0);
    e1    = sb_match(sb_e, ra1, d_use1, 1'b0);
    e0_ld = sb_match(sb_e, ra0, d_use0, 1'b1);
    e1_ld = sb_match(sb_e, ra1, d_use1, 1'b1);
    m0    = sb_match(sb_m, ra0, d_use0, 1'b0);
    m1    = sb_match(sb_m, ra1, d_use1, 1'b0);
    w0    = sb_match(sb_w, ra0, d_use0, 1'b0);
    w1    = sb_match(sb_w, ra1, d_use1, 1'b0);
    if (FWD_EN != 0) hazard = e0_ld || e1_ld;
    else             hazard = e0 || e1 || m0 || m1;
  end

  // armed keeps every control output quiet for the first cycle after reset.
  assign redirect = armed && m_redirect;
  assign stall_d  = armed && hazard && !redirect;
  assign stall_f  = stall_d;
  assign flush_d  = redirect;
  assign flush_e  = redirect || stall_d;
  assign flush_m  = redirect;
  assign e_bubble = stall_d || flush_e || !d_valid;

  always_comb begin
    d_entry         = SB_EMPTY;
    d_entry.valid   = 1'b1;
    d_entry.we      = d_rf_we;
    d_entry.wa      = SB_WA_W'(d_wa);
    d_entry.is_load = d_is_load;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      armed <= 1'b0;
      sb_e  <= SB_EMPTY;
      sb_m  <= SB_EMPTY;
      sb_w  <= SB_EMPTY;
    end else begin
      armed <= 1'b1;
      sb_w  <= sb_m;
      sb_m  <= flush_m ? SB_EMPTY : sb_e;
      sb_e  <= e_bubble ? SB_EMPTY : d_entry;
    end
  end

  // Selects are resolved in D and travel with the instruction into E.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fwd_a_q <= FWD_RF;
      fwd_b_q <= FWD_RF;
    end else if ((FWD_EN == 0) || e_bubble) begin
      fwd_a_q <= FWD_RF;
      fwd_b_q <= FWD_RF;
    end else begin
      fwd_a_q <= pick_fwd(e0 && !e0_ld, m0, w0);
      fwd_b_q <= pick_fwd(e1 && !e1_ld, m1, w1);
    end
  end

  assign fwd_a = fwd_a_q;
  assign fwd_b = fwd_b_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (stall_d),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (redirect),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl (forwarding and stall-only builds)
module tb_hazard_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       d_valid, d_use0, d_use1, d_rf_we, d_is_load, m_redirect;
  logic [4:0] d_ra0, d_ra1, d_wa;

  logic        sf[2], sdo[2], fdo[2], feo[2], fmo[2];
  logic [1:0]  fa[2], fb[2];
  logic [31:0] scnt1, fcnt1;
  logic [3:0]  scnt0, fcnt0;

  always #5 clock = ~clock;

  hazard_ctrl #(.REG_ADDR_W(5), .FWD_EN(1), .CNT_W(32)) dut1 (
    .clock(clock), .reset(reset), .d_valid(d_valid), .d_ra0(d_ra0), .d_ra1(d_ra1),
    .d_use0(d_use0), .d_use1(d_use1), .d_rf_we(d_rf_we), .d_wa(d_wa),
    .d_is_load(d_is_load), .m_redirect(m_redirect),
    .stall_f(sf[1]), .stall_d(sdo[1]), .flush_d(fdo[1]), .flush_e(feo[1]),
    .flush_m(fmo[1]), .fwd_a(fa[1]), .fwd_b(fb[1]),
    .stall_cnt(scnt1), .flush_cnt(fcnt1)
  );

  hazard_ctrl #(.REG_ADDR_W(5), .FWD_EN(0), .CNT_W(4)) dut0 (
    .clock(clock), .reset(reset), .d_valid(d_valid), .d_ra0(d_ra0), .d_ra1(d_ra1),
    .d_use0(d_use0), .d_use1(d_use1), .d_rf_we(d_rf_we), .d_wa(d_wa),
    .d_is_load(d_is_load), .m_redirect(m_redirect),
    .stall_f(sf[0]), .stall_d(sdo[0]), .flush_d(fdo[0]), .flush_e(feo[0]),
    .flush_m(fmo[0]), .fwd_a(fa[0]), .fwd_b(fb[0]),
    .stall_cnt(scnt0), .flush_cnt(fcnt0)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model: a per-cycle log of which real writers entered E; age 1 = E, age 2 = M.
  bit         lg_v [2][8];
  bit [4:0]   lg_wa[2][8];
  bit         lg_ld[2][8];
  int         cyc = 0;
  bit         armed_m;
  logic [1:0] mfa[2], mfb[2];
  longint     mscnt[2], mfcnt[2], cap[2];
  bit         snap_sd[2], snap_fe[2], snap_fd[2], snap_fm[2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [63:0] cnt_s(int k);
    return (k == 1) ? 64'(scnt1) : 64'(scnt0);
  endfunction

  function automatic logic [63:0] cnt_f(int k);
    return (k == 1) ? 64'(fcnt1) : 64'(fcnt0);
  endfunction

  function automatic bit hit(int k, int age, bit [4:0] ra, bit u);
    int s;
    s = (cyc - age) & 7;
    return lg_v[k][s] && (lg_wa[k][s] == ra) && (ra != 5'd0) && u;
  endfunction

  task automatic model_clear;
    for (int k = 0; k < 2; k++) begin
      for (int s = 0; s < 8; s++) lg_v[k][s] = 1'b0;
      mfa[k] = 2'd0; mfb[k] = 2'd0; mscnt[k] = 0; mfcnt[k] = 0;
    end
    armed_m = 1'b0;
  endtask

  task automatic set_in(input bit dv, input bit [4:0] r0, input bit [4:0] r1, input bit u0,
                        input bit u1, input bit we, input bit [4:0] wa, input bit ld, input bit rd);
    d_valid = dv; d_ra0 = r0; d_ra1 = r1; d_use0 = u0; d_use1 = u1;
    d_rf_we = we; d_wa = wa; d_is_load = ld; m_redirect = rd;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    #1;
    model_clear();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst k%0d stall_d", k), 64'(sdo[k]), 64'd0);
      chk($sformatf("rst k%0d flush_e", k), 64'(feo[k]), 64'd0);
      chk($sformatf("rst k%0d fwd_a", k), 64'(fa[k]), 64'd0);
      chk($sformatf("rst k%0d stall_cnt", k), cnt_s(k), 64'd0);
      chk($sformatf("rst k%0d flush_cnt", k), cnt_f(k), 64'd0);
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic cycle(input bit dv, input bit [4:0] r0, input bit [4:0] r1, input bit u0,
                       input bit u1, input bit we, input bit [4:0] wa, input bit ld, input bit rd);
    bit sd[2], fe[2], bub[2], redir;
    logic [1:0] na[2], nb[2];
    set_in(dv, r0, r1, u0, u1, we, wa, ld, rd);
    redir = armed_m && rd;
    for (int k = 0; k < 2; k++) begin
      bit ea, eb, ma, mb, hz;
      ea = hit(k, 1, r0, u0); eb = hit(k, 1, r1, u1);
      ma = hit(k, 2, r0, u0); mb = hit(k, 2, r1, u1);
      if (k == 1) hz = (ea || eb) && lg_ld[k][(cyc - 1) & 7];
      else        hz = ea || eb || ma || mb;
      sd[k]  = armed_m && hz && !redir;
      fe[k]  = redir || sd[k];
      bub[k] = !dv || fe[k];
      na[k]  = (k == 0 || bub[k]) ? 2'd0 : ea ? 2'd1 : ma ? 2'd2 : 2'd0;
      nb[k]  = (k == 0 || bub[k]) ? 2'd0 : eb ? 2'd1 : mb ? 2'd2 : 2'd0;
    end
    @(negedge clock);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("k%0d stall_f", k), 64'(sf[k]), 64'(sd[k]));
      chk($sformatf("k%0d stall_d", k), 64'(sdo[k]), 64'(sd[k]));
      chk($sformatf("k%0d flush_d", k), 64'(fdo[k]), 64'(redir));
      chk($sformatf("k%0d flush_e", k), 64'(feo[k]), 64'(fe[k]));
      chk($sformatf("k%0d flush_m", k), 64'(fmo[k]), 64'(redir));
      chk($sformatf("k%0d fwd_a", k), 64'(fa[k]), 64'(mfa[k]));
      chk($sformatf("k%0d fwd_b", k), 64'(fb[k]), 64'(mfb[k]));
      chk($sformatf("k%0d stall_cnt", k), cnt_s(k), 64'(mscnt[k]));
      chk($sformatf("k%0d flush_cnt", k), cnt_f(k), 64'(mfcnt[k]));
      snap_sd[k] = sdo[k]; snap_fe[k] = feo[k]; snap_fd[k] = fdo[k]; snap_fm[k] = fmo[k];
    end
    @(posedge clock);
    for (int k = 0; k < 2; k++) begin
      if (sd[k] && mscnt[k] < cap[k]) mscnt[k]++;
      if (redir && mfcnt[k] < cap[k]) mfcnt[k]++;
      mfa[k] = na[k]; mfb[k] = nb[k];
      if (redir) lg_v[k][(cyc - 1) & 7] = 1'b0;
      lg_v[k][cyc & 7]  = !bub[k] && we;
      lg_wa[k][cyc & 7] = wa;
      lg_ld[k][cyc & 7] = ld;
    end
    cyc++;
    armed_m = 1'b1;
    #1;
  endtask

  task automatic nop;
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic alu(input bit [4:0] rd, input bit [4:0] rs, input bit [4:0] rt);
    cycle(1, rs, rt, 1, 1, 1, rd, 0, 0);
  endtask

  task automatic lw(input bit [4:0] rt, input bit [4:0] rs);
    cycle(1, rs, 0, 1, 0, 1, rt, 1, 0);
  endtask

  initial begin
    cap[0] = 15;
    cap[1] = 64'hFFFF_FFFF;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    do_reset();
    nop();

    alu(3, 1, 2); alu(4, 3, 1);
    chk("b2b stall_d", 64'(snap_sd[1]), 64'd0);
    chk("b2b fwd_a", 64'(fa[1]), 64'd1);
    chk("b2b stall_cnt", 64'(scnt1), 64'd0);

    repeat (3) nop();
    alu(3, 1, 2); nop(); alu(5, 3, 3);
    chk("gap2 fwd_a", 64'(fa[1]), 64'd2);
    chk("gap2 fwd_b", 64'(fb[1]), 64'd2);

    repeat (3) nop();
    lw(6, 1); alu(7, 6, 2);
    chk("lu stall_d", 64'(snap_sd[1]), 64'd1);
    chk("lu flush_e", 64'(snap_fe[1]), 64'd1);
    alu(7, 6, 2);
    chk("lu stall once", 64'(snap_sd[1]), 64'd0);
    chk("lu fwd_a", 64'(fa[1]), 64'd2);
    chk("lu stall_cnt", 64'(scnt1), 64'd1);

    repeat (3) nop();
    alu(0, 1, 2); alu(4, 0, 0);
    chk("r0 stall_d", 64'(snap_sd[1]), 64'd0);
    chk("r0 fwd_a", 64'(fa[1]), 64'd0);
    chk("r0 fwd_b", 64'(fb[1]), 64'd0);

    do_reset();
    nop(); lw(6, 1);
    alu(7, 6, 2); chk("nofwd stall E", 64'(snap_sd[0]), 64'd1);
    alu(7, 6, 2); chk("nofwd stall M", 64'(snap_sd[0]), 64'd1);
    alu(7, 6, 2); chk("nofwd released", 64'(snap_sd[0]), 64'd0);
    chk("nofwd stall_cnt", 64'(scnt0), 64'd2);
    chk("nofwd fwd_a", 64'(fa[0]), 64'd0);

    repeat (3) nop();
    lw(6, 1);
    cycle(1, 6, 2, 1, 1, 1, 7, 0, 1);
    chk("redir flush_d", 64'(snap_fd[1]), 64'd1);
    chk("redir flush_e", 64'(snap_fe[1]), 64'd1);
    chk("redir flush_m", 64'(snap_fm[1]), 64'd1);
    chk("redir stall_d", 64'(snap_sd[1]), 64'd0);
    chk("redir flush_cnt", 64'(fcnt1), 64'd1);
    chk("redir stall_cnt", 64'(scnt1), 64'd1);
    alu(9, 6, 7);
    chk("squashed fwd_a", 64'(fa[1]), 64'd0);
    chk("squashed fwd_b", 64'(fb[1]), 64'd0);

    repeat (3) nop();
    lw(6, 1);
    set_in(1, 6, 2, 1, 1, 1, 7, 0, 0);
    #2;
    chk("midstall stall_d", 64'(sdo[1]), 64'd1);
    do_reset();
    cycle(1, 6, 2, 1, 1, 1, 7, 0, 1);
    chk("post-rst flush_d quiet", 64'(snap_fd[1]), 64'd0);
    alu(8, 6, 2);
    chk("post-rst sb empty", 64'(snap_sd[1]), 64'd0);

    repeat (1500) begin
      cycle($urandom_range(0, 3) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
            5'($urandom_range(0, 3)), $urandom_range(0, 2) == 0, $urandom_range(0, 11) == 0);
    end
    chk("sat stall_cnt0", 64'(scnt0), 64'd15);
    chk("sat flush_cnt0", 64'(fcnt0), 64'd15);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
